// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default limits for the pipeline control unit.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } ctrl_state_e;

    typedef struct packed {
        logic en;
        logic flush;
    } stage_ctrl_t;

    localparam int unsigned DEF_MC_TIMEOUT  = 64;
    localparam int unsigned DEF_MEM_TIMEOUT = 256;
    localparam int unsigned DEF_CNT_W       = 9;

endpackage

// File: rtl/ctrl_wait_timer.sv
// Saturating wait counter; o_hit flags the cycle whose count reaches THRESH.
module ctrl_wait_timer #(
    parameter int unsigned CNT_W  = 9,
    parameter int unsigned THRESH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_hit
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (i_clr) begin
            w_cnt_nxt = '0;
        end else if (i_inc && (r_cnt != '1)) begin
            w_cnt_nxt = r_cnt + 1'b1;
        end
    end

    // Looking at the next count lets the sticky flag rise in the threshold cycle itself.
    assign o_hit = i_inc && !i_clr && (w_cnt_nxt >= CNT_W'(THRESH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end

endmodule

// File: rtl/pipeline_ctrl_unit.sv
// Pipeline freeze/stall/flush sequencer with wait-timeout supervision.
// Optional perf counters are built when PIPE_CTRL_PERF_EN is defined.
module pipeline_ctrl_unit
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MC_TIMEOUT  = DEF_MC_TIMEOUT,
    parameter int unsigned MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter int unsigned CNT_W       = DEF_CNT_W
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hz_stall,
    input  logic        hz_flush_id,
    input  logic        hz_flush_ex,
    input  logic        mc_start,
    input  logic        mc_done,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic        exmem_flush,
    output logic [1:0]  ctrl_state,
    output logic        err_mc_timeout,
    output logic        err_mem_timeout
`ifdef PIPE_CTRL_PERF_EN
   ,output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_flush_count,
    output logic [31:0] perf_mem_wait_cycles
`endif
);

    ctrl_state_e r_state, r_ret_state;
    ctrl_state_e w_next, w_ret_nxt, w_eval;
    logic        r_err_mc, r_err_mem;
    logic        w_mc_hit, w_mem_hit;
    logic        w_illegal, w_freeze, w_mc_hold, w_lu, w_ctl, w_ex_bubble;
    logic        w_pc_en, w_memwb_en;
    stage_ctrl_t w_ifid, w_idex, w_exmem;

    always_comb begin
        w_illegal   = 1'b0;
        w_freeze    = 1'b0;
        w_mc_hold   = 1'b0;
        w_lu        = 1'b0;
        w_ctl       = 1'b0;
        w_ex_bubble = 1'b0;
        w_ret_nxt   = r_ret_state;
        // A completed memory wait behaves exactly like the state it interrupted.
        case (r_state)
            RUN, MC_WAIT: w_eval = r_state;
            MEM_WAIT:     w_eval = r_ret_state;
            default: begin
                w_eval    = RUN;
                w_illegal = 1'b1;
            end
        endcase
        w_next = w_eval;

        if (w_illegal || (r_state == MEM_WAIT && !dmem_ready)) begin
            w_freeze = 1'b1;
            w_next   = w_illegal ? RUN : MEM_WAIT;
        end else if (dmem_req && !dmem_ready) begin
            w_freeze  = 1'b1;
            w_next    = MEM_WAIT;
            w_ret_nxt = w_eval;
        end else if (w_eval == MC_WAIT) begin
            if (mc_done) begin
                w_next = RUN;
            end else begin
                w_mc_hold = 1'b1;
            end
        end else if (mc_start && !mc_done) begin
            w_mc_hold = 1'b1;
            w_next    = MC_WAIT;
        end else if (hz_stall) begin
            w_lu = 1'b1;
        end else begin
            w_ctl       = hz_flush_id;
            w_ex_bubble = hz_flush_ex;
        end

        w_pc_en       = !(w_freeze || w_mc_hold || w_lu);
        w_ifid.en     = w_pc_en;
        w_ifid.flush  = w_ctl;
        w_idex.en     = !(w_freeze || w_mc_hold);
        w_idex.flush  = w_lu || w_ex_bubble;
        w_exmem.en    = !w_freeze;
        w_exmem.flush = w_mc_hold;
        w_memwb_en    = !w_freeze;
    end

    ctrl_wait_timer #(
        .CNT_W  (CNT_W),
        .THRESH (MC_TIMEOUT)
    ) u_mc_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_next != MC_WAIT),
        .i_inc (w_next == MC_WAIT),
        .o_hit (w_mc_hit)
    );

    ctrl_wait_timer #(
        .CNT_W  (CNT_W),
        .THRESH (MEM_TIMEOUT)
    ) u_mem_timer (
        .clk   (clk),
        .rst   (rst),
        .i_clr (w_next != MEM_WAIT),
        .i_inc (w_next == MEM_WAIT),
        .o_hit (w_mem_hit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= RUN;
            r_ret_state <= RUN;
            r_err_mc    <= 1'b0;
            r_err_mem   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ret_state <= w_ret_nxt;
            r_err_mc    <= r_err_mc  | w_mc_hit;
            r_err_mem   <= r_err_mem | w_mem_hit;
        end
    end

    assign pc_en           = w_pc_en;
    assign ifid_en         = w_ifid.en;
    assign idex_en         = w_idex.en;
    assign exmem_en        = w_exmem.en;
    assign memwb_en        = w_memwb_en;
    assign ifid_flush      = w_ifid.flush;
    assign idex_flush      = w_idex.flush;
    assign exmem_flush     = w_exmem.flush;
    assign ctrl_state      = r_state;
    assign err_mc_timeout  = r_err_mc;
    assign err_mem_timeout = r_err_mem;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] r_perf_stall, r_perf_flush, r_perf_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_perf_stall <= '0;
            r_perf_flush <= '0;
            r_perf_mem   <= '0;
        end else begin
            if (!w_pc_en)            r_perf_stall <= r_perf_stall + 32'd1;
            if (w_ifid.flush)        r_perf_flush <= r_perf_flush + 32'd1;
            if (r_state == MEM_WAIT) r_perf_mem   <= r_perf_mem + 32'd1;
        end
    end

    assign perf_stall_cycles    = r_perf_stall;
    assign perf_flush_count     = r_perf_flush;
    assign perf_mem_wait_cycles = r_perf_mem;
`endif

endmodule

// File: tb/tb_pipeline_ctrl_unit.sv
// Directed bench for pipeline_ctrl_unit with hand-computed enable/flush vectors.
module tb_pipeline_ctrl_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       hz_stall, hz_flush_id, hz_flush_ex, mc_start, mc_done, dmem_req, dmem_ready;
    logic       pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic       ifid_flush, idex_flush, exmem_flush;
    logic [1:0] ctrl_state;
    logic       err_mc_timeout, err_mem_timeout;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // {pc, ifid, idex, exmem, memwb enables, ifid, idex, exmem flushes}
    localparam logic [7:0] V_RUN  = 8'b11111_000;
    localparam logic [7:0] V_FRZ  = 8'b00000_000;
    localparam logic [7:0] V_MC   = 8'b00011_001;
    localparam logic [7:0] V_LU   = 8'b00111_010;
    localparam logic [7:0] V_CTL1 = 8'b11111_110;
    localparam logic [7:0] V_CTL0 = 8'b11111_100;

    // {hz_stall, hz_flush_id, hz_flush_ex, mc_start, mc_done, dmem_req, dmem_ready}
    localparam logic [6:0] I_IDLE = 7'b000_00_00;
    localparam logic [6:0] I_HS   = 7'b100_00_00;
    localparam logic [6:0] I_HSF  = 7'b111_00_00;
    localparam logic [6:0] I_FID1 = 7'b011_00_00;
    localparam logic [6:0] I_FID0 = 7'b010_00_00;
    localparam logic [6:0] I_MS   = 7'b000_10_00;
    localparam logic [6:0] I_MD   = 7'b000_01_00;
    localparam logic [6:0] I_MSMD = 7'b000_11_00;
    localparam logic [6:0] I_DREQ = 7'b000_00_10;
    localparam logic [6:0] I_DRDY = 7'b000_00_11;

    pipeline_ctrl_unit #(
        .MC_TIMEOUT  (16),
        .MEM_TIMEOUT (8),
        .CNT_W       (9)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .hz_stall        (hz_stall),
        .hz_flush_id     (hz_flush_id),
        .hz_flush_ex     (hz_flush_ex),
        .mc_start        (mc_start),
        .mc_done         (mc_done),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .exmem_flush     (exmem_flush),
        .ctrl_state      (ctrl_state),
        .err_mc_timeout  (err_mc_timeout),
        .err_mem_timeout (err_mem_timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ctl_vec();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush, exmem_flush};
    endfunction

    task automatic chk_cyc(input string tag, input logic [7:0] ev, input logic [1:0] es);
        check_eq({tag, ".ctl"}, 32'(ctl_vec()), 32'(ev));
        check_eq({tag, ".st"}, 32'(ctrl_state), 32'(es));
    endtask

    task automatic apply(input logic [6:0] v);
        {hz_stall, hz_flush_id, hz_flush_ex, mc_start, mc_done, dmem_req, dmem_ready} = v;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        {hz_stall, hz_flush_id, hz_flush_ex, mc_start, mc_done, dmem_req, dmem_ready} = I_IDLE;
        #1 rst = 1'b1;
        #2;
        chk_cyc("reset", V_RUN, 2'd0);
        check_eq("reset.err_mc", 32'(err_mc_timeout), 32'd0);
        check_eq("reset.err_mem", 32'(err_mem_timeout), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        apply(I_IDLE); chk_cyc("idle", V_RUN, 2'd0);
        tick(); apply(I_HS);   chk_cyc("loaduse", V_LU, 2'd0);
        tick(); apply(I_IDLE); chk_cyc("loaduse_after", V_RUN, 2'd0);
        tick(); apply(I_HSF);  chk_cyc("loaduse_prio", V_LU, 2'd0);
        tick(); apply(I_FID1); chk_cyc("ctl_ex", V_CTL1, 2'd0);
        apply(I_FID0);         chk_cyc("ctl", V_CTL0, 2'd0);

        tick(); apply(I_MS);   chk_cyc("mc_start", V_MC, 2'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); apply(I_IDLE); chk_cyc($sformatf("mc_wait%0d", i), V_MC, 2'd1);
        end
        tick(); apply(I_MD);   chk_cyc("mc_done", V_RUN, 2'd1);
        tick(); apply(I_IDLE); chk_cyc("mc_ret", V_RUN, 2'd0);

        tick(); apply(I_MS);   chk_cyc("mc2_start", V_MC, 2'd0);
        tick(); apply(I_DREQ); chk_cyc("mc_mem0", V_FRZ, 2'd1);
        for (int i = 1; i < 3; i++) begin
            tick(); apply(I_DREQ); chk_cyc($sformatf("mc_mem%0d", i), V_FRZ, 2'd2);
        end
        tick(); apply(I_DRDY); chk_cyc("mem_rdy", V_MC, 2'd2);
        tick(); apply(I_IDLE); chk_cyc("mem_ret", V_MC, 2'd1);
        tick(); apply(I_MD);   chk_cyc("mc2_done", V_RUN, 2'd1);
        tick(); apply(I_IDLE); chk_cyc("mc2_ret", V_RUN, 2'd0);

        tick(); apply(I_DRDY); chk_cyc("mem_hit", V_RUN, 2'd0);
        tick(); apply(I_MSMD); chk_cyc("mc_same", V_RUN, 2'd0);
        tick(); apply(I_IDLE); chk_cyc("mc_same_after", V_RUN, 2'd0);

        tick(); apply(I_DREQ); chk_cyc("memto_enter", V_FRZ, 2'd0);
        for (int k = 1; k <= 10; k++) begin
            tick(); apply(I_DREQ);
            chk_cyc($sformatf("memto%0d", k), V_FRZ, 2'd2);
            check_eq($sformatf("memto%0d.err", k), 32'(err_mem_timeout), (k >= 8) ? 32'd1 : 32'd0);
        end
        check_eq("memto.err_mc", 32'(err_mc_timeout), 32'd0);

        #2 rst = 1'b1;
        #1;
        check_eq("rst_mid.st", 32'(ctrl_state), 32'd0);
        check_eq("rst_mid.err_mem", 32'(err_mem_timeout), 32'd0);
        apply(I_IDLE); chk_cyc("rst_mid", V_RUN, 2'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        apply(I_MS); chk_cyc("mcto_start", V_MC, 2'd0);
        for (int k = 1; k <= 17; k++) begin
            tick(); apply(I_IDLE);
            check_eq($sformatf("mcto%0d.st", k), 32'(ctrl_state), 32'd1);
            check_eq($sformatf("mcto%0d.err", k), 32'(err_mc_timeout), (k >= 16) ? 32'd1 : 32'd0);
        end
        tick(); apply(I_MD);   chk_cyc("mcto_done", V_RUN, 2'd1);
        tick(); apply(I_IDLE); chk_cyc("mcto_ret", V_RUN, 2'd0);
        check_eq("mcto_sticky", 32'(err_mc_timeout), 32'd1);
        check_eq("mcto.err_mem", 32'(err_mem_timeout), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
